sc_stoch_to_bin: RTL and testbench
==================================

Name: sc_stoch_to_bin

Overview:
Stochastic-to-binary converter sitting directly downstream of the adder tree. It consumes the tree's single output bitstream and counts ones over a fixed window of 2^WIDTH valid samples. It then presents the count as a binary value with a one-cycle done pulse. Windowing is started by a start strobe from the control logic, and in_valid lets the upstream pipeline stall without corrupting the count.

Parameters:
WIDTH, 8, log2 of window length; window = 2^WIDTH valid samples; minimum 1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
start  input  1  begins a new conversion window when sampled high in IDLE or DONE.
in_bit  input  1  stochastic bitstream sample, typically the adder tree output.
in_valid  input  1  in_bit is counted only on cycles where in_valid is high.
busy  output  1  high while a window is in progress (state COUNT).
done  output  1  one-cycle pulse; result is valid from this cycle onward.
result  output  WIDTH+1  count of ones in the last completed window, unsigned 0..2^WIDTH; width is WIDTH+2 signed when the optional feature is enabled.

Behaviour:
- Reset (rst=0, async): state=IDLE; ones_cnt=0, sample_cnt=0, result=0, busy=0, done=0. Reset mid-window discards the window. No done pulse follows release of reset.
- States: IDLE, COUNT, DONE.
- IDLE: start=1 -> COUNT; ones_cnt and sample_cnt cleared on the same edge. in_bit and in_valid are ignored on that start cycle.
- COUNT: busy=1.
  - On each edge with in_valid=1: sample_cnt+=1; ones_cnt+=in_bit.
  - in_valid=0: both counters hold.
  - start is ignored in COUNT; there is no restart or abort.
- Last sample: the edge that takes sample_cnt from 2^WIDTH-1 to wrap, with in_valid=1.
  - result <= ones_cnt + in_bit, which includes the final sample.
  - State -> DONE.
- DONE lasts exactly one cycle: done=1, busy=0, result holds its new value.
  - start=1 in DONE -> COUNT with counters cleared, giving back-to-back windows with one dead cycle.
  - Otherwise DONE -> IDLE.
- result holds until the next completed window; it is unchanged by a new start.
- Width rules:
  - sample_cnt is WIDTH bits and wraps naturally.
  - ones_cnt is WIDTH+1 bits; max value 2^WIDTH (all ones) without overflow.
- Latency: done is asserted the cycle after the edge that accepted the 2^WIDTH-th valid sample. Minimum start-to-done is 2^WIDTH+1 cycles.
- The upstream tree's registered levels add fixed latency. Control must hold in_valid low until the tree output is meaningful; this block does not compensate for it.

Optional Feature:
Macro SC_STOCH_TO_BIN_BIPOLAR_EN.
- Defined: result is WIDTH+2 bits signed, two's complement, equal to 2*ones - 2^WIDTH (bipolar SC encoding). Range -2^WIDTH..+2^WIDTH. Conversion is applied in the same cycle result is registered, so latency is unchanged.
- Undefined: result is WIDTH+1 bits unsigned, equal to the raw ones count.

Decomposition:
- Shared package sc_pkg holds:
  - the state enum (IDLE, COUNT, DONE) as a 2-bit typedef;
  - a localparam helper for window length (1<<WIDTH).
  - Future converters in the codebase reuse both.
- One natural sub-module: sc_ones_counter, holding the gated WIDTH+1-bit ones counter and the WIDTH-bit sample counter with clear/enable/wrap flag. The FSM and result register stay in the top.

Test Plan:
- WIDTH=4; start, then 16 cycles in_valid=1, in_bit=1 -> done on cycle 17 after start, result=16, busy low in the done cycle.
- WIDTH=4; in_bit alternating 1,0 for 16 valid cycles -> result=8; all zeros -> result=0.
- WIDTH=4; in_valid toggled 1,0 each cycle with in_bit=1 -> done after 32 counting cycles, result=16. Verifies stall holds both counters.
- WIDTH=4; start pulsed again at cycle 5 of COUNT -> ignored, single done, result unchanged from an unstalled run. start held in the DONE cycle -> next window begins immediately, busy=1 next cycle.
- WIDTH=4; rst driven low at sample 9 -> result=0, busy=0, done=0 asynchronously. No done pulse after release until a new start and 16 valid samples.
- With SC_STOCH_TO_BIN_BIPOLAR_EN, WIDTH=4 -> all ones gives +16, all zeros gives -16 (6'b110000), alternating gives 0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for stochastic-computing converters: conversion state
// encoding and window-length helper.
package sc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } sc_state_e;

  localparam int unsigned ScDefaultWidth = 8;

  function automatic int unsigned sc_window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Gated ones counter plus sample counter for one conversion window; flags the
// sample that completes the window.
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH = ScDefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in_bit,
  output logic [WIDTH:0]   ones_cnt,
  output logic [WIDTH-1:0] sample_cnt,
  output logic             last
);

  localparam logic [WIDTH-1:0] LastIdx = WIDTH'(sc_window_len(WIDTH) - 1);

  // Combinational so the owner can capture the final sample on the same edge.
  assign last = en && (sample_cnt == LastIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else if (clr) begin
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else if (en) begin
      ones_cnt   <= ones_cnt + {{WIDTH{1'b0}}, in_bit};
      sample_cnt <= sample_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over 2^WIDTH valid samples.
// SC_STOCH_TO_BIN_BIPOLAR_EN selects a signed bipolar result (2*ones - 2^WIDTH).
module sc_stoch_to_bin
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH = ScDefaultWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_bit,
  input  logic                    in_valid,
  output logic                    busy,
  output logic                    done,
`ifdef SC_STOCH_TO_BIN_BIPOLAR_EN
  output logic signed [WIDTH+1:0] result
`else
  output logic        [WIDTH:0]   result
`endif
);

  sc_state_e state;

  logic             clr;
  logic             en;
  logic             last;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH-1:0] sample_cnt;
  logic [WIDTH:0]   ones_sum;

`ifdef SC_STOCH_TO_BIN_BIPOLAR_EN
  logic [WIDTH+1:0] res_d;
`else
  logic [WIDTH:0]   res_d;
`endif

  assign clr = start && (state != StCount);
  assign en  = in_valid && (state == StCount);

  sc_ones_counter #(
    .WIDTH(WIDTH)
  ) u_ones_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (en),
    .in_bit    (in_bit),
    .ones_cnt  (ones_cnt),
    .sample_cnt(sample_cnt),
    .last      (last)
  );

  // Final sample is folded in here since the counter only updates on this edge.
  assign ones_sum = ones_cnt + {{WIDTH{1'b0}}, in_bit};

  always_comb begin
`ifdef SC_STOCH_TO_BIN_BIPOLAR_EN
    res_d = {ones_sum, 1'b0} - {2'b01, {WIDTH{1'b0}}};
`else
    res_d = ones_sum;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state <= StCount;
            busy  <= 1'b1;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        StCount: begin
          if (last) begin
            state  <= StDone;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_d;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// Randomized self-checking bench for sc_stoch_to_bin at WIDTH=4; the reference
// model just tallies accepted samples per window.
module tb_sc_stoch_to_bin;

  localparam int unsigned Width  = 4;
  localparam int unsigned Window = 1 << Width;
`ifdef SC_STOCH_TO_BIN_BIPOLAR_EN
  localparam int unsigned ResW = Width + 2;
`else
  localparam int unsigned ResW = Width + 1;
`endif

  logic            clk;
  logic            rst;
  logic            start;
  logic            in_bit;
  logic            in_valid;
  logic            busy;
  logic            done;
  logic [ResW-1:0] result;

  int unsigned checks;
  int unsigned errors;
  logic [ResW-1:0] held_result;

  sc_stoch_to_bin #(
    .WIDTH(Width)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_bit  (in_bit),
    .in_valid(in_valid),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected converter output for a window holding `ones` ones.
  function automatic logic [ResW-1:0] expect_result(input int unsigned ones);
    logic [ResW-1:0] r;
`ifdef SC_STOCH_TO_BIN_BIPOLAR_EN
    r = ResW'(2 * ones) - ResW'(Window);
`else
    r = ResW'(ones);
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 all ones, 1 alternating, 2 all zeros, 3 random bits
  // stall: 0 none, 1 toggle valid each cycle, 2 random valid
  task automatic run_window(input int mode, input int stall, input bit skip_start,
                            input bit mid_start, input bit chain);
    bit          samples[$];
    int unsigned ones;
    int          iter;
    bit          v;
    bit          b;
    if (!skip_start) begin
      start    = 1'b1;
      in_bit   = 1'($urandom);
      in_valid = 1'($urandom);
      step();
      start = 1'b0;
    end
    check_eq("busy_after_start", busy, 1);
    iter = 0;
    while (samples.size() < Window) begin
      unique case (stall)
        0:       v = 1'b1;
        1:       v = (iter % 2) == 0;
        default: v = (iter > 150) ? 1'b1 : 1'($urandom);
      endcase
      unique case (mode)
        0:       b = 1'b1;
        1:       b = (samples.size() % 2) == 0;
        2:       b = 1'b0;
        default: b = 1'($urandom);
      endcase
      in_valid = v;
      in_bit   = b;
      start    = mid_start && (iter == 5);
      if (v) samples.push_back(b);
      step();
      start = 1'b0;
      iter++;
      if (samples.size() < Window) begin
        check_eq("busy_counting", busy, 1);
        check_eq("done_early", done, 0);
        check_eq("result_held_counting", result, held_result);
      end
      if (iter > 200) begin
        check_eq("window_timeout", iter, 0);
        break;
      end
    end
    ones = 0;
    foreach (samples[i]) ones += samples[i];
    check_eq("done_pulse", done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("result", result, expect_result(ones));
    held_result = expect_result(ones);
    in_valid = 1'($urandom);
    in_bit   = 1'($urandom);
    start    = chain;
    step();
    start = 1'b0;
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after_done", busy, chain ? 1 : 0);
    check_eq("result_held_after", result, held_result);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    held_result = '0;
    rst         = 1'b0;
    start       = 1'b0;
    in_bit      = 1'b0;
    in_valid    = 1'b0;
    repeat (3) step();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_result", result, 0);
    rst = 1'b1;
    step();
    check_eq("no_done_after_reset", done, 0);

    run_window(0, 0, 1'b0, 1'b0, 1'b0);  // all ones
    run_window(1, 0, 1'b0, 1'b0, 1'b0);  // alternating
    run_window(2, 0, 1'b0, 1'b0, 1'b0);  // all zeros
    run_window(0, 1, 1'b0, 1'b0, 1'b0);  // stall toggling
    run_window(3, 0, 1'b0, 1'b1, 1'b1);  // mid-window start ignored, chained next
    run_window(3, 2, 1'b1, 1'b0, 1'b0);  // back-to-back window, random stalls
    for (int k = 0; k < 6; k++) run_window(3, 2, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a window.
    start = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (9) step();
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_done", done, 0);
    check_eq("async_rst_result", result, 0);
    held_result = '0;
    step();
    rst = 1'b1;
    for (int c = 0; c < 2 * Window + 4; c++) begin
      in_valid = 1'($urandom);
      in_bit   = 1'($urandom);
      step();
      if (done !== 1'b0 || busy !== 1'b0) check_eq("idle_after_reset", {busy, done}, 0);
    end
    check_eq("idle_result_after_reset", result, 0);
    run_window(3, 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
